inst_queue: RTL

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue.sv | 75 +++++++
 1 files changed

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry circular buffer
// with flush, registered pointers/count and masked head outputs.
module inst_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              fetch_valid_i,
  input  logic [31:0]       fetch_pc_i,
  input  logic [31:0]       fetch_inst_i,
  output logic              fetch_ready_o,
  input  logic              decode_ready_i,
  output logic              inst_valid_o,
  output logic [31:0]       pc_o,
  output logic [31:0]       inst_o,
  input  logic              flush_i,
  output logic [PTR_W:0]    count_o,
  output logic              full_o,
  output logic              empty_o
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [PTR_W:0]    count_q;
  logic              push;
  logic              pop;
  entry_t            head_entry;

  // Status derives from the registered count only, so ready never depends on decode.
  assign full_o        = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o       = (count_q == '0);
  assign fetch_ready_o = ~full_o;
  assign inst_valid_o  = ~empty_o;
  assign count_o       = count_q;

  assign push = fetch_valid_i & fetch_ready_o;
  assign pop  = inst_valid_o & decode_ready_i;

  assign head_entry = mem[head_q];
  assign pc_o       = inst_valid_o ? head_entry.pc   : 32'h0;
  assign inst_o     = inst_valid_o ? head_entry.inst : 32'h0;

  // Pointer and count state; flush overrides any push or pop in the same cycle.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + (PTR_W+1)'(1);
      else if (pop && !push) count_q <= count_q - (PTR_W+1)'(1);
    end
  end

  // Entry storage is never cleared; stale contents are hidden by the output mask.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      mem[tail_q] <= '{pc: fetch_pc_i, inst: fetch_inst_i};
    end
  end

endmodule
